// File: rtl/mc_addr_incr.sv
// Pipelined burst address incrementer: LW-bit low segment advances each
// cycle, carry into the high segment is registered and applied one cycle
// later. Supports linear and aligned wrap4/8/16 bursts with a last-beat flag.
module mc_addr_incr #(
  parameter int AW = 32,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [AW-1:0] ld_addr,
  input  logic [1:0]    bl_sel,
  input  logic          inc,
  output logic          inc_rdy,
  output logic [AW-1:0] addr,
  output logic          addr_vld,
  output logic          last
);

  localparam int HW = AW - LW;

  logic [AW-1:0] addr_q, addr_d;
  logic          carry_q, carry_d;
  logic [1:0]    mode_q, mode_d;
  logic [3:0]    beat_q, beat_d;
  logic          loaded_q, loaded_d;

  logic          ready, acc;
  logic [LW:0]   low_sum;
  logic [HW-1:0] high_sum;
  logic [3:0]    wmask, last_beat, nib_inc, nib_wrap;

  // Incrementer is blocked while a carry is in flight or before the first load.
  assign ready    = loaded_q & ~carry_q;
  assign acc      = inc & ready & ~ld;

  assign low_sum  = {1'b0, addr_q[LW-1:0]} + (LW+1)'(1);
  assign high_sum = addr_q[AW-1:LW] + HW'(1);
  assign nib_inc  = addr_q[3:0] + 4'd1;
  // Wrap modes only touch the bottom K bits; bits above K are kept from addr.
  assign nib_wrap = (addr_q[3:0] & ~wmask) | (nib_inc & wmask);

  // Wrap mask and final beat index for the active burst mode.
  always_comb begin
    wmask     = 4'b0000;
    last_beat = 4'd0;
    case (mode_q)
      2'b01:   begin wmask = 4'b0011; last_beat = 4'd3;  end
      2'b10:   begin wmask = 4'b0111; last_beat = 4'd7;  end
      2'b11:   begin wmask = 4'b1111; last_beat = 4'd15; end
      default: begin wmask = 4'b0000; last_beat = 4'd0;  end
    endcase
  end

  assign last     = (mode_q != 2'b00) & (beat_q == last_beat);
  assign inc_rdy  = ready;
  assign addr_vld = ready;
  assign addr     = addr_q;

  // Next state: load wins, then the deferred high-segment carry, then inc.
  always_comb begin
    addr_d   = addr_q;
    carry_d  = carry_q;
    mode_d   = mode_q;
    beat_d   = beat_q;
    loaded_d = loaded_q;
    if (ld) begin
      addr_d   = ld_addr;
      mode_d   = bl_sel;
      beat_d   = 4'd0;
      carry_d  = 1'b0;
      loaded_d = 1'b1;
    end else if (carry_q) begin
      addr_d[AW-1:LW] = high_sum;
      carry_d         = 1'b0;
    end else if (acc) begin
      if (mode_q == 2'b00) begin
        addr_d[LW-1:0] = low_sum[LW-1:0];
        carry_d        = low_sum[LW];
      end else begin
        addr_d[3:0] = nib_wrap;
        beat_d      = last ? 4'd0 : beat_q + 4'd1;
      end
    end
  end

  // State register; reset discards any pending carry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      carry_q  <= 1'b0;
      mode_q   <= 2'b00;
      beat_q   <= 4'd0;
      loaded_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      carry_q  <= carry_d;
      mode_q   <= mode_d;
      beat_q   <= beat_d;
      loaded_q <= loaded_d;
    end
  end

endmodule

// File: tb/tb_mc_addr_incr.sv
// Directed bench for mc_addr_incr (AW=32, LW=16).
module tb_mc_addr_incr;

  logic        clk;
  logic        rst;
  logic        ld;
  logic [31:0] ld_addr;
  logic [1:0]  bl_sel;
  logic        inc;
  logic        inc_rdy;
  logic [31:0] addr;
  logic        addr_vld;
  logic        last;

  int pass_cnt = 0;
  int total_cnt = 0;

  mc_addr_incr #(.AW(32), .LW(16)) dut (
    .clk(clk), .rst(rst), .ld(ld), .ld_addr(ld_addr), .bl_sel(bl_sel),
    .inc(inc), .inc_rdy(inc_rdy), .addr(addr), .addr_vld(addr_vld), .last(last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] m);
    ld = 1'b1; ld_addr = a; bl_sel = m;
    tick;
    ld = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; ld = 1'b0; ld_addr = '0; bl_sel = 2'b00; inc = 1'b0;
    #12;
    total_cnt++;
    if (addr !== 32'h0 || addr_vld !== 1'b0 || inc_rdy !== 1'b0 || last !== 1'b0)
      $display("FAIL reset: addr=%h vld=%b rdy=%b last=%b want 0/0/0/0", addr, addr_vld, inc_rdy, last);
    else pass_cnt++;
    rst = 1'b1;
    #3;
    inc = 1'b1;
    tick; tick;
    inc = 1'b0;
    total_cnt++;
    if (addr !== 32'h0 || inc_rdy !== 1'b0)
      $display("FAIL inc_before_load: addr=%h rdy=%b want 00000000/0", addr, inc_rdy);
    else pass_cnt++;
  endtask

  task automatic test_linear;
    logic [31:0] exp [3];
    exp[0] = 32'h11; exp[1] = 32'h12; exp[2] = 32'h13;
    do_load(32'h0000_0010, 2'b00);
    total_cnt++;
    if (addr !== 32'h10 || addr_vld !== 1'b1)
      $display("FAIL linear_load: addr=%h vld=%b want 00000010/1", addr, addr_vld);
    else pass_cnt++;
    inc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total_cnt++;
      if (addr !== exp[i] || addr_vld !== 1'b1 || last !== 1'b0)
        $display("FAIL linear_step%0d: addr=%h vld=%b last=%b want %h/1/0", i, addr, addr_vld, last, exp[i]);
      else pass_cnt++;
    end
    inc = 1'b0;
  endtask

  task automatic test_carry;
    do_load(32'h0001_FFFF, 2'b00);
    inc = 1'b1;
    tick;
    total_cnt++;
    if (addr !== 32'h0001_0000 || addr_vld !== 1'b0 || inc_rdy !== 1'b0)
      $display("FAIL carry_bubble: addr=%h vld=%b rdy=%b want 00010000/0/0", addr, addr_vld, inc_rdy);
    else pass_cnt++;
    tick;
    total_cnt++;
    if (addr !== 32'h0002_0000 || addr_vld !== 1'b1)
      $display("FAIL carry_apply: addr=%h vld=%b want 00020000/1", addr, addr_vld);
    else pass_cnt++;
    tick;
    inc = 1'b0;
    total_cnt++;
    if (addr !== 32'h0002_0001 || addr_vld !== 1'b1)
      $display("FAIL carry_held_inc: addr=%h vld=%b want 00020001/1", addr, addr_vld);
    else pass_cnt++;
  endtask

  task automatic test_wrap8;
    logic [31:0] exp [8];
    exp[0] = 32'h100F; exp[1] = 32'h1008; exp[2] = 32'h1009; exp[3] = 32'h100A;
    exp[4] = 32'h100B; exp[5] = 32'h100C; exp[6] = 32'h100D; exp[7] = 32'h100E;
    do_load(32'h0000_100E, 2'b10);
    total_cnt++;
    if (last !== 1'b0 || addr !== 32'h100E)
      $display("FAIL wrap8_load: addr=%h last=%b want 0000100e/0", addr, last);
    else pass_cnt++;
    inc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      total_cnt++;
      if (addr !== exp[i] || addr_vld !== 1'b1 || last !== (i == 6))
        $display("FAIL wrap8_beat%0d: addr=%h vld=%b last=%b want %h/1/%0d", i, addr, addr_vld, last, exp[i], (i == 6));
      else pass_cnt++;
    end
    inc = 1'b0;
  endtask

  task automatic test_overflow;
    do_load(32'hFFFF_FFFF, 2'b00);
    inc = 1'b1;
    tick;
    inc = 1'b0;
    total_cnt++;
    if (addr !== 32'hFFFF_0000 || addr_vld !== 1'b0)
      $display("FAIL overflow_low: addr=%h vld=%b want ffff0000/0", addr, addr_vld);
    else pass_cnt++;
    tick;
    total_cnt++;
    if (addr !== 32'h0 || addr_vld !== 1'b1)
      $display("FAIL overflow_high: addr=%h vld=%b want 00000000/1", addr, addr_vld);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous;
    do_load(32'h0000_0040, 2'b00);
    inc = 1'b1;
    do_load(32'h0000_5555, 2'b00);
    inc = 1'b0;
    total_cnt++;
    if (addr !== 32'h0000_5555)
      $display("FAIL ld_with_inc: addr=%h want 00005555", addr);
    else pass_cnt++;
    do_load(32'h0003_FFFF, 2'b00);
    inc = 1'b1;
    tick;
    inc = 1'b0;
    do_load(32'hABCD_0001, 2'b00);
    total_cnt++;
    if (addr !== 32'hABCD_0001 || addr_vld !== 1'b1)
      $display("FAIL ld_in_bubble: addr=%h vld=%b want abcd0001/1", addr, addr_vld);
    else pass_cnt++;
    tick;
    total_cnt++;
    if (addr !== 32'hABCD_0001 || addr_vld !== 1'b1)
      $display("FAIL ld_in_bubble_hold: addr=%h vld=%b want abcd0001/1", addr, addr_vld);
    else pass_cnt++;
  endtask

  task automatic test_async_reset;
    do_load(32'h1234_FFFF, 2'b00);
    inc = 1'b1;
    tick;
    inc = 1'b0;
    total_cnt++;
    if (addr !== 32'h1234_0000 || addr_vld !== 1'b0)
      $display("FAIL areset_setup: addr=%h vld=%b want 12340000/0", addr, addr_vld);
    else pass_cnt++;
    #2;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (addr !== 32'h0 || addr_vld !== 1'b0 || inc_rdy !== 1'b0)
      $display("FAIL areset_immediate: addr=%h vld=%b rdy=%b want 00000000/0/0", addr, addr_vld, inc_rdy);
    else pass_cnt++;
    #3;
    rst = 1'b1;
    inc = 1'b1;
    tick; tick;
    inc = 1'b0;
    total_cnt++;
    if (addr !== 32'h0 || addr_vld !== 1'b0 || inc_rdy !== 1'b0)
      $display("FAIL areset_inc_ignored: addr=%h vld=%b rdy=%b want 00000000/0/0", addr, addr_vld, inc_rdy);
    else pass_cnt++;
    do_load(32'h0000_0020, 2'b00);
    inc = 1'b1;
    tick;
    inc = 1'b0;
    total_cnt++;
    if (addr !== 32'h21 || addr_vld !== 1'b1)
      $display("FAIL areset_resume: addr=%h vld=%b want 00000021/1", addr, addr_vld);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_linear;
    test_carry;
    test_wrap8;
    test_overflow;
    test_simultaneous;
    test_async_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
